// File: rtl/serial_logic_unit_if.sv
// ---------------------------------------------------------------------------
// serial_logic_unit_if
//   Request/result bundle for the serial bitwise logic unit.
//   Ports (as seen from the requester / master side):
//     start  out  request strobe, honoured only while the unit is ready
//     op     out  2-bit opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
//     A, B   out  N-bit operands, latched on an accepted start
//     busy   in   high while the unit is processing digits
//     done   in   one-cycle pulse when C/zero have just been updated
//     C      in   N-bit result register, held until the next completion
//     zero   in   high when C == 0
// ---------------------------------------------------------------------------
interface serial_logic_unit_if #(
  parameter int N = 32
) ();
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] C;
  logic         zero;

  modport master (
    output start, op, A, B,
    input  busy, done, C, zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, C, zero
  );
endinterface

// File: rtl/serial_logic_unit.sv
// ---------------------------------------------------------------------------
// serial_logic_unit
//   Multi-cycle bitwise logic unit (AND / OR / XOR / NOR). Operands are
//   latched on an accepted start and processed DIGIT_W bits per clock,
//   least-significant digit first. The final result is written to C (with
//   its zero flag) in a single step and announced by a one-cycle done pulse.
//   Parameters:
//     N        operand/result width in bits
//     DIGIT_W  bits processed per clock (N must be a multiple of DIGIT_W)
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of serial_logic_unit_if (start/op/A/B in,
//            busy/done/C/zero out)
// ---------------------------------------------------------------------------
module serial_logic_unit #(
  parameter int N       = 32,
  parameter int DIGIT_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_logic_unit_if.slave    bus
);

  if ((DIGIT_W < 1) || (DIGIT_W > N) || ((N % DIGIT_W) != 0)) begin : g_bad_digit_w
    $error("serial_logic_unit: N must be a positive multiple of DIGIT_W");
  end

  localparam int K     = N / DIGIT_W;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [N-1:0]       sa;
  logic [N-1:0]       sb;
  logic [N-1:0]       sr;
  logic [N-1:0]       sr_next;
  logic [1:0]         op_r;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT_W-1:0] digit;
  logic               accept;

  // A request is only looked at outside RUN, so start (and any X on the
  // operand lines) cannot disturb a computation in flight.
  assign accept = (state != RUN) && bus.start;

  // Per-digit logic function; digits are independent, no carry chain.
  always_comb begin
    digit = '0;
    case (op_r)
      2'b00:   digit = sa[DIGIT_W-1:0] & sb[DIGIT_W-1:0];
      2'b01:   digit = sa[DIGIT_W-1:0] | sb[DIGIT_W-1:0];
      2'b10:   digit = sa[DIGIT_W-1:0] ^ sb[DIGIT_W-1:0];
      default: digit = ~(sa[DIGIT_W-1:0] | sb[DIGIT_W-1:0]);
    endcase
  end

  // New digit enters at the MSB end; after K shifts the first digit has
  // reached bit 0, so SR ends up in natural bit order.
  always_comb begin
    sr_next                   = sr >> DIGIT_W;
    sr_next[N-1 -: DIGIT_W]   = digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = bus.start ? RUN : IDLE;
      RUN:     next_state = (cnt == LAST) ? DONE : RUN;
      DONE:    next_state = bus.start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy/done decode the state register only, so there is no
  // combinational path from the request inputs to the outputs.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Datapath: C and zero are written only on the completion edge, so
  // partial results never become visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      op_r     <= 2'b00;
      cnt      <= '0;
      bus.C    <= '0;
      bus.zero <= 1'b1;
    end else if (accept) begin
      sa   <= bus.A;
      sb   <= bus.B;
      op_r <= bus.op;
      sr   <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> DIGIT_W;
      sb  <= sb >> DIGIT_W;
      sr  <= sr_next;
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST) begin
        bus.C    <= sr_next;
        bus.zero <= (sr_next == '0);
      end
    end
  end

endmodule
